// File: rtl/pulp_cluster_package.sv
`default_nettype none
// ============================================================================
// Module      : pulp_cluster_package
// Description : Shared cluster types: address map rules, peripheral routes,
//               and the decode-error response word.
// Revision    : 1.0 - initial release
// ============================================================================
package pulp_cluster_package;

    localparam int unsigned PERIPH_NB_SLAVES = 10;
    localparam int unsigned PERIPH_ID_WIDTH  = 5;
    localparam int unsigned PERIPH_SLV_WIDTH =
        (PERIPH_NB_SLAVES > 1) ? $clog2(PERIPH_NB_SLAVES) : 1;

    localparam logic [31:0] PERIPH_DEMUX_ERR_RDATA = 32'hBADACCE5;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    // err=1 means the internal error responder owns the transaction
    typedef struct packed {
        logic                        err;
        logic [PERIPH_SLV_WIDTH-1:0] slv;
        logic [PERIPH_ID_WIDTH-1:0]  id;
    } periph_route_t;

endpackage
`default_nettype wire

// File: rtl/periph_route_fifo.sv
`default_nettype none
// ============================================================================
// Module      : periph_route_fifo
// Description : Synchronous FIFO of periph_route_t with wrap-around pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_route_fifo
    import pulp_cluster_package::*;
#(
    parameter  int unsigned DEPTH   = 4,
    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  periph_route_t i_data,
    input  logic          i_pop,
    output periph_route_t o_head,
    output logic          o_full,
    output logic          o_empty
);

    periph_route_t        r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/cluster_periph_demux.sv
`default_nettype none
// ============================================================================
// Module      : cluster_periph_demux
// Description : Rule-table demux from the periph interconnect master to
//               NB_SLAVES plugs, in-order responses, internal error responder.
//               Optional decode-error counter: CLUSTER_PERIPH_DEMUX_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_periph_demux
    import pulp_cluster_package::*;
#(
    parameter int unsigned NB_SLAVES       = PERIPH_NB_SLAVES,
    parameter int unsigned NB_RULES        = 10,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = PERIPH_ID_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  addr_map_rule_t [NB_RULES-1:0]        rules_i,
    input  logic                                 req_i,
    input  logic [31:0]                          add_i,
    input  logic                                 wen_i,
    input  logic [DATA_WIDTH-1:0]                wdata_i,
    input  logic [DATA_WIDTH/8-1:0]              be_i,
    input  logic [ID_WIDTH-1:0]                  id_i,
    output logic                                 gnt_o,
    output logic                                 r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic [ID_WIDTH-1:0]                  r_id_o,
    output logic [NB_SLAVES-1:0]                 slv_req_o,
    output logic [31:0]                          slv_add_o,
    output logic                                 slv_wen_o,
    output logic [DATA_WIDTH-1:0]                slv_wdata_o,
    output logic [DATA_WIDTH/8-1:0]              slv_be_o,
    input  logic [NB_SLAVES-1:0]                 slv_gnt_i,
    input  logic [NB_SLAVES-1:0]                 slv_r_valid_i,
    input  logic [NB_SLAVES-1:0][DATA_WIDTH-1:0] slv_r_rdata_i,
    input  logic [NB_SLAVES-1:0]                 slv_r_opc_i,
    output logic [15:0]                          err_cnt_o
);

    localparam logic [DATA_WIDTH-1:0] c_ERR_RDATA = DATA_WIDTH'(PERIPH_DEMUX_ERR_RDATA);

    logic                        w_hit;
    logic [PERIPH_SLV_WIDTH-1:0] w_sel;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_accept;
    logic [NB_SLAVES-1:0]        w_slv_req;
    periph_route_t               w_push_route;
    periph_route_t               w_head;
    logic                        w_head_resp;

    logic                        r_rsp_valid;
    logic [DATA_WIDTH-1:0]       r_rsp_rdata;
    logic                        r_rsp_opc;
    logic [ID_WIDTH-1:0]         r_rsp_id;

    // Scan from the top so the lowest-index matching rule is the last writer
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int r = int'(NB_RULES) - 1; r >= 0; r--) begin
            if ((rules_i[r].idx < NB_SLAVES) &&
                (rules_i[r].end_addr > rules_i[r].start_addr) &&
                (add_i >= rules_i[r].start_addr) &&
                (add_i < rules_i[r].end_addr)) begin
                w_hit = 1'b1;
                w_sel = rules_i[r].idx[PERIPH_SLV_WIDTH-1:0];
            end
        end
    end

    assign w_accept = req_i & ~w_full;

    always_comb begin
        w_slv_req = '0;
        if (w_accept && w_hit) w_slv_req[w_sel] = 1'b1;
    end

    assign slv_req_o   = w_slv_req;
    assign gnt_o       = w_accept & (~w_hit | slv_gnt_i[w_sel]);
    assign slv_add_o   = add_i;
    assign slv_wen_o   = wen_i;
    assign slv_wdata_o = wdata_i;
    assign slv_be_o    = be_i;

    assign w_push_route.err = ~w_hit;
    assign w_push_route.slv = w_sel;
    assign w_push_route.id  = PERIPH_ID_WIDTH'(id_i);

    periph_route_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (gnt_o),
        .i_data  (w_push_route),
        .i_pop   (w_head_resp),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Only the slave owning the head route can complete; ERR completes at once
    assign w_head_resp = ~w_empty & (w_head.err | slv_r_valid_i[w_head.slv]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_opc   <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_head_resp;
            if (w_head_resp) begin
                r_rsp_id <= ID_WIDTH'(w_head.id);
                if (w_head.err) begin
                    r_rsp_opc   <= 1'b1;
                    r_rsp_rdata <= c_ERR_RDATA;
                end else begin
                    r_rsp_opc   <= slv_r_opc_i[w_head.slv];
                    r_rsp_rdata <= slv_r_rdata_i[w_head.slv];
                end
            end
        end
    end

    assign r_valid_o = r_rsp_valid;
    assign r_rdata_o = r_rsp_rdata;
    assign r_opc_o   = r_rsp_opc;
    assign r_id_o    = r_rsp_id;

`ifdef CLUSTER_PERIPH_DEMUX_ERR_CNT_EN
    logic [NB_SLAVES-1:0] w_consumed;
    logic                 w_stray;
    logic [16:0]          w_err_sum;
    logic [15:0]          r_err_cnt;

    assign w_consumed = (~w_empty & ~w_head.err & slv_r_valid_i[w_head.slv])
                        ? (NB_SLAVES'(1) << w_head.slv) : '0;
    assign w_stray    = |(slv_r_valid_i & ~w_consumed);
    assign w_err_sum  = {1'b0, r_err_cnt} + 17'(gnt_o & ~w_hit) + 17'(w_stray);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_periph_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_periph_demux
// Description : Directed scenarios plus randomized traffic against a
//               transaction-queue reference model of the demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_periph_demux;
    import pulp_cluster_package::*;

    localparam int NS = 10;
    localparam int NR = 10;
    localparam int DW = 32;
    localparam int IW = 5;
    localparam int MO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    addr_map_rule_t [NR-1:0]  rules;
    logic                     req;
    logic [31:0]              add;
    logic                     wen;
    logic [DW-1:0]            wdata;
    logic [DW/8-1:0]          be;
    logic [IW-1:0]            id;
    logic                     gnt;
    logic                     r_valid;
    logic [DW-1:0]            r_rdata;
    logic                     r_opc;
    logic [IW-1:0]            r_id;
    logic [NS-1:0]            slv_req;
    logic [31:0]              slv_add;
    logic                     slv_wen;
    logic [DW-1:0]            slv_wdata;
    logic [DW/8-1:0]          slv_be;
    logic [NS-1:0]            slv_gnt;
    logic [NS-1:0]            slv_r_valid;
    logic [NS-1:0][DW-1:0]    slv_r_rdata;
    logic [NS-1:0]            slv_r_opc;
    logic [15:0]              err_cnt;

    cluster_periph_demux #(
        .NB_SLAVES       (NS),
        .NB_RULES        (NR),
        .DATA_WIDTH      (DW),
        .ID_WIDTH        (IW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rules_i       (rules),
        .req_i         (req),
        .add_i         (add),
        .wen_i         (wen),
        .wdata_i       (wdata),
        .be_i          (be),
        .id_i          (id),
        .gnt_o         (gnt),
        .r_valid_o     (r_valid),
        .r_rdata_o     (r_rdata),
        .r_opc_o       (r_opc),
        .r_id_o        (r_id),
        .slv_req_o     (slv_req),
        .slv_add_o     (slv_add),
        .slv_wen_o     (slv_wen),
        .slv_wdata_o   (slv_wdata),
        .slv_be_o      (slv_be),
        .slv_gnt_i     (slv_gnt),
        .slv_r_valid_i (slv_r_valid),
        .slv_r_rdata_i (slv_r_rdata),
        .slv_r_opc_i   (slv_r_opc),
        .err_cnt_o     (err_cnt)
    );

    typedef struct {
        bit err;
        int slv;
        int id;
    } txn_t;

    txn_t        q[$];
    logic        e_valid;
    logic [31:0] e_rdata;
    logic        e_opc;
    int          e_id;
    int          e_cnt;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First matching rule in table order wins; -1 stands for the error responder
    function automatic int ref_target(input logic [31:0] a);
        for (int r = 0; r < NR; r++) begin
            if (rules[r].idx < NS && rules[r].start_addr <= a && a < rules[r].end_addr)
                return int'(rules[r].idx);
        end
        return -1;
    endfunction

    task automatic idle();
        req         = 1'b0;
        add         = 32'h0;
        wen         = 1'b1;
        wdata       = '0;
        be          = '1;
        id          = '0;
        slv_gnt     = '0;
        slv_r_valid = '0;
        slv_r_rdata = '0;
        slv_r_opc   = '0;
    endtask

    task automatic clear_rules();
        for (int r = 0; r < NR; r++)
            rules[r] = '{idx: 32'hFFFF_FFFF, start_addr: 32'h0, end_addr: 32'h0};
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        e_valid = 1'b0; e_rdata = '0; e_opc = 1'b0; e_id = 0; e_cnt = 0;
        chk("rst.r_valid", r_valid, 0);
        chk("rst.r_opc",   r_opc,   0);
        chk("rst.r_rdata", r_rdata, 0);
        chk("rst.r_id",    r_id,    0);
        chk("rst.err_cnt", err_cnt, 0);
    endtask

    // One clock cycle with the currently driven inputs, checked against the model
    task automatic step(input string tag);
        int            tgt;
        bit            full, g, resp, stray;
        logic [NS-1:0] req_exp, used;
        txn_t          h;
        #2;
        tgt     = ref_target(add);
        full    = (q.size() >= MO);
        g       = req && !full && (tgt < 0 || slv_gnt[tgt]);
        req_exp = '0;
        if (req && !full && tgt >= 0) req_exp[tgt] = 1'b1;
        chk({tag, ".gnt"},     gnt,     g);
        chk({tag, ".slv_req"}, slv_req, req_exp);
        chk({tag, ".slv_add"}, slv_add, add);
        resp = 1'b0;
        used = '0;
        h    = '{err: 1'b0, slv: 0, id: 0};
        if (q.size() > 0) begin
            h    = q[0];
            resp = h.err || slv_r_valid[h.slv];
            if (resp && !h.err) used[h.slv] = 1'b1;
        end
        stray = |(slv_r_valid & ~used);
        if (resp) begin
            e_rdata = h.err ? 32'hBADACCE5 : slv_r_rdata[h.slv];
            e_opc   = h.err ? 1'b1 : slv_r_opc[h.slv];
            e_id    = h.id;
        end
        e_valid = resp;
        @(posedge clk); #1;
        if (resp) q.delete(0);
        if (g) q.push_back('{err: (tgt < 0), slv: (tgt < 0) ? 0 : tgt, id: int'(id)});
`ifdef CLUSTER_PERIPH_DEMUX_ERR_CNT_EN
        e_cnt = e_cnt + int'(g && tgt < 0) + int'(stray);
        if (e_cnt > 65535) e_cnt = 65535;
`endif
        chk({tag, ".r_valid"}, r_valid, e_valid);
        chk({tag, ".r_rdata"}, r_rdata, e_rdata);
        chk({tag, ".r_opc"},   r_opc,   e_opc);
        chk({tag, ".r_id"},    r_id,    e_id);
        chk({tag, ".err_cnt"}, err_cnt, e_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_rules();
        idle();
        do_reset();

        // Basic read routed to slave 4
        rules[0] = '{idx: 32'd0, start_addr: 32'h1000, end_addr: 32'h1400};
        rules[1] = '{idx: 32'd4, start_addr: 32'h1400, end_addr: 32'h1800};
        req = 1'b1; add = 32'h1404; id = 5'd3; slv_gnt = 10'b00000_10000;
        #1 chk("tp1.slv_req", slv_req, 10'b00000_10000);
        step("tp1_req");
        idle();
        slv_r_valid = 10'b00000_10000;
        slv_r_rdata[4] = 32'h0000_CAFE;
        step("tp1_rsp");
        chk("tp1.r_valid", r_valid, 1);
        chk("tp1.r_rdata", r_rdata, 32'h0000_CAFE);
        chk("tp1.r_id",    r_id,    3);
        chk("tp1.r_opc",   r_opc,   0);
        idle();
        step("tp1_idle");

        // Overlapping rules: lowest index wins
        clear_rules();
        rules[0] = '{idx: 32'd1, start_addr: 32'h0,    end_addr: 32'h2000};
        rules[1] = '{idx: 32'd2, start_addr: 32'h1000, end_addr: 32'h1100};
        req = 1'b1; add = 32'h1010; id = 5'd9; slv_gnt = '1;
        #1 chk("tp2.slv_req", slv_req, 10'b00000_00010);
        step("tp2_req");
        idle(); slv_r_valid[1] = 1'b1; slv_r_rdata[1] = 32'h1234_5678;
        step("tp2_rsp");
        idle();
        step("tp2_idle");

        // Unmapped address answered by the error responder
        do_reset();
        req = 1'b1; add = 32'h9000_0000; id = 5'd17;
        #1 chk("tp3.gnt", gnt, 1);
        step("tp3_req");
        idle();
        step("tp3_rsp");
        chk("tp3.r_valid", r_valid, 1);
        chk("tp3.r_opc",   r_opc,   1);
        chk("tp3.r_rdata", r_rdata, 32'hBADACCE5);
        chk("tp3.r_id",    r_id,    17);
`ifdef CLUSTER_PERIPH_DEMUX_ERR_CNT_EN
        chk("tp3.err_cnt", err_cnt, 1);
`else
        chk("tp3.err_cnt", err_cnt, 0);
`endif

        // Fill the route FIFO with withheld responses
        clear_rules();
        rules[0] = '{idx: 32'd0, start_addr: 32'h1000, end_addr: 32'h1400};
        for (int i = 0; i < MO; i++) begin
            idle(); req = 1'b1; add = 32'h1004; id = IW'(i); slv_gnt = '1;
            step("tp4_fill");
        end
        id = 5'd4;
        #1 chk("tp4.full_gnt", gnt, 0);
        chk("tp4.full_req", slv_req, 0);
        step("tp4_full");
        slv_r_valid[0] = 1'b1;
        step("tp4_pop");
        slv_r_valid = '0;
        #1 chk("tp4.regnt", gnt, 1);
        step("tp4_regnt");
        for (int i = 0; i < MO; i++) begin
            idle(); slv_r_valid[0] = 1'b1;
            step("tp4_drain");
        end

        // Non-head slave response is ignored, order preserved
        clear_rules();
        rules[0] = '{idx: 32'd1, start_addr: 32'h2000, end_addr: 32'h2100};
        rules[1] = '{idx: 32'd2, start_addr: 32'h3000, end_addr: 32'h3100};
        idle(); req = 1'b1; slv_gnt = '1; add = 32'h2010; id = 5'd7;
        step("tp5_req1");
        add = 32'h3010; id = 5'd8;
        step("tp5_req2");
        idle(); slv_r_valid[2] = 1'b1; slv_r_rdata[2] = 32'hAAAA_0002;
        step("tp5_ooo");
        chk("tp5.ooo_valid", r_valid, 0);
        idle(); slv_r_valid[1] = 1'b1; slv_r_rdata[1] = 32'hAAAA_0001;
        step("tp5_rsp1");
        chk("tp5.id1", r_id, 7);
        idle(); slv_r_valid[2] = 1'b1; slv_r_rdata[2] = 32'hAAAA_0022;
        step("tp5_rsp2");
        chk("tp5.id2", r_id, 8);
        chk("tp5.rdata2", r_rdata, 32'hAAAA_0022);

        // Reset with routes in flight, then a late slave response
        clear_rules();
        rules[0] = '{idx: 32'd0, start_addr: 32'h1000, end_addr: 32'h1400};
        for (int i = 0; i < 3; i++) begin
            idle(); req = 1'b1; add = 32'h1008; id = IW'(20 + i); slv_gnt = '1;
            step("tp6_fill");
        end
        do_reset();
        slv_r_valid[0] = 1'b1; req = 1'b1; add = 32'h1008; id = 5'd1; slv_gnt = '1;
        #1 chk("tp6.gnt", gnt, 1);
        step("tp6_stray");
        chk("tp6.r_valid", r_valid, 0);
        idle(); slv_r_valid[0] = 1'b1;
        step("tp6_rsp");

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 200 == 0) begin
                for (int r = 0; r < NR; r++) begin
                    logic [31:0] s;
                    logic [31:0] e;
                    s = 32'($urandom_range(0, 15)) << 8;
                    e = s + (32'($urandom_range(0, 6)) << 8);
                    if ($urandom_range(0, 9) == 0) e = s - 32'h100;
                    rules[r] = '{idx: 32'($urandom_range(0, 12)), start_addr: s, end_addr: e};
                end
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            req   = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0:       add = $urandom;
                1:       add = (32'($urandom_range(0, 23)) << 8);
                2:       add = (32'($urandom_range(1, 23)) << 8) - 32'd1;
                default: add = 32'($urandom_range(0, 32'h17FF));
            endcase
            wen     = 1'($urandom_range(0, 1));
            wdata   = $urandom;
            be      = 4'($urandom_range(0, 15));
            id      = IW'($urandom_range(0, 31));
            slv_gnt = NS'($urandom);
            for (int s = 0; s < NS; s++) begin
                slv_r_valid[s] = ($urandom_range(0, 9) == 0);
                slv_r_rdata[s] = $urandom;
                slv_r_opc[s]   = 1'($urandom_range(0, 1));
            end
            if (q.size() > 0 && !q[0].err && $urandom_range(0, 1) == 1)
                slv_r_valid[q[0].slv] = 1'b1;
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
